hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have parameter REG_ADDR_WIDTH, default 5, register-address width.
REQ-002 The block SHALL have parameter STALL_CYCLES, default 1, legal range 1..3, the number of frozen cycles per load-use hazard.
REQ-003 The block SHALL have these ports:
- clk  in  1  clock; one clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- IF_ID_inst_opcode  in  7  opcode of the instruction in ID
- IF_ID_rs1  in  REG_ADDR_WIDTH  rs1 of the instruction in ID
- IF_ID_rs2  in  REG_ADDR_WIDTH  rs2 of the instruction in ID
- ID_EX_inst_opcode  in  7  opcode held in ID/EX
- ID_EX_rd  in  REG_ADDR_WIDTH  rd held in ID/EX
- ID_EX_pc_sel  in  1  branch/jump taken, resolved in EX
- perf_clr  in  1  clear performance counters
- pc_write_en  out  1  PC update enable
- IF_ID_write_en  out  1  IF/ID load enable
- IF_ID_flush  out  1  IF/ID invalidate
- ctr_sel  out  1  1 = pass ID control into ID/EX; 0 = bubble
- stall_count  out  16  frozen-cycle counter
- flush_count  out  16  flush counter

Function
REQ-004 The block SHALL implement an FSM with two states: RUN and STALL, plus a 2-bit down-counter cnt.
REQ-005 Hazard detection SHALL be masked in STALL and in any cycle with ID_EX_pc_sel=1.
REQ-006 load_use SHALL be true when all of the following hold:
- ID_EX_inst_opcode=7'b0000011
- ID_EX_rd!=0
- either ID_EX_rd==IF_ID_rs1, or ID_EX_rd==IF_ID_rs2 with IF_ID_inst_opcode in {0110011, 0100011, 1100011}
REQ-007 Outputs SHALL be combinational from state, cnt and current inputs.
REQ-008 In RUN with no flush and no load_use, outputs SHALL be pc_write_en=1, IF_ID_write_en=1, ctr_sel=1, IF_ID_flush=0.
REQ-009 RUN with load_use SHALL drive:
- pc_write_en=0, IF_ID_write_en=0, ctr_sel=0, IF_ID_flush=0
- next state STALL, cnt<=STALL_CYCLES-1
REQ-010 STALL with cnt>0 SHALL drive pc_write_en=0, IF_ID_write_en=0, ctr_sel=0, and cnt<=cnt-1.
REQ-011 STALL with cnt==0 (release) SHALL drive:
- pc_write_en=1, IF_ID_write_en=1, ctr_sel=1, IF_ID_flush=0
- next state RUN
REQ-012 Total frozen cycles per hazard SHALL equal STALL_CYCLES, followed by exactly one release cycle.
REQ-013 ID_EX_pc_sel=1 in either state SHALL take priority and drive:
- IF_ID_flush=1, ctr_sel=0, pc_write_en=1, IF_ID_write_en=1
- next state RUN, cnt<=0 (aborts any stall)
REQ-014 stall_count SHALL increment by 1 in every non-reset cycle with pc_write_en=0, saturating at 16'hFFFF.
REQ-015 flush_count SHALL increment by 1 in every cycle with IF_ID_flush=1, saturating at 16'hFFFF.
REQ-016 perf_clr=1 SHALL zero both counters on the next edge, taking priority over increment; the FSM is unaffected.
REQ-017 A hazard whose ID_EX_rd is 0 SHALL never stall.
REQ-018 Back-to-back dependent loads (e.g. lw x5,0(x5) after lw x5) SHALL each stall exactly once; release-cycle masking prevents a self-re-trigger.

Reset
REQ-019 On reset=1 at a rising edge, the block SHALL set state=RUN, cnt=0, stall_count=0, flush_count=0.
REQ-020 While reset=1, outputs SHALL be pc_write_en=0, IF_ID_write_en=0, ctr_sel=0, IF_ID_flush=0.
REQ-021 Reset asserted mid-STALL SHALL abandon the stall; the first cycle after release SHALL use RUN outputs.

Verification
REQ-022 The bench SHALL cover these scenarios:
- STALL_CYCLES=1; ID_EX opcode=0000011, rd=5; IF_ID rs1=5 -> one cycle pc_write_en=0/ctr_sel=0, next cycle all enables 1, stall_count=1.
- STALL_CYCLES=3; same hazard -> pc_write_en=0 for 3 cycles, release on 4th, stall_count=3.
- ID_EX rd=0 with IF_ID rs1=0 on a load; or rs2 match with IF_ID opcode 0010011 -> no stall, counters unchanged.
- ID_EX_pc_sel=1 during STALL cnt=1 (STALL_CYCLES=3) -> IF_ID_flush=1, pc_write_en=1, state RUN next cycle, flush_count=1.
- stall_count preloaded to FFFF via 65535 stalls, one more stall -> stays FFFF; then perf_clr=1 -> 0 next cycle.
- reset=1 in STALL -> all outputs 0 that cycle; after reset=0, RUN outputs and counters 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall insertion, branch/jump flush,
// and saturating performance counters for frozen and flushed cycles.
module hazard_ctrl #(
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned STALL_CYCLES   = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [6:0]                IF_ID_inst_opcode,
    input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs2,
    input  logic [6:0]                ID_EX_inst_opcode,
    input  logic [REG_ADDR_WIDTH-1:0] ID_EX_rd,
    input  logic                      ID_EX_pc_sel,
    input  logic                      perf_clr,
    output logic                      pc_write_en,
    output logic                      IF_ID_write_en,
    output logic                      IF_ID_flush,
    output logic                      ctr_sel,
    output logic [15:0]               stall_count,
    output logic [15:0]               flush_count
);

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;

    // Frozen cycles beyond the detection cycle itself.
    localparam logic [1:0] StallInit = 2'(STALL_CYCLES - 1);

    typedef enum logic [0:0] {
        StRun,
        StStall
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [15:0] stall_count_q, flush_count_q;

    logic uses_rs2;
    logic rs1_match;
    logic rs2_match;
    logic load_use;

    // rs2 is only a real source operand for R-type, store and branch formats.
    always_comb begin
        uses_rs2  = (IF_ID_inst_opcode == OpReg) ||
                    (IF_ID_inst_opcode == OpStore) ||
                    (IF_ID_inst_opcode == OpBranch);
        rs1_match = (ID_EX_rd == IF_ID_rs1);
        rs2_match = (ID_EX_rd == IF_ID_rs2) && uses_rs2;
        load_use  = (ID_EX_inst_opcode == OpLoad) &&
                    (ID_EX_rd != '0) &&
                    (rs1_match || rs2_match);
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        pc_write_en    = 1'b1;
        IF_ID_write_en = 1'b1;
        ctr_sel        = 1'b1;
        IF_ID_flush    = 1'b0;

        if (reset) begin
            pc_write_en    = 1'b0;
            IF_ID_write_en = 1'b0;
            ctr_sel        = 1'b0;
            state_d        = StRun;
            cnt_d          = 2'd0;
        end else if (ID_EX_pc_sel) begin
            // Redirect wins over everything, including an in-progress stall.
            IF_ID_flush = 1'b1;
            ctr_sel     = 1'b0;
            state_d     = StRun;
            cnt_d       = 2'd0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (load_use) begin
                        pc_write_en    = 1'b0;
                        IF_ID_write_en = 1'b0;
                        ctr_sel        = 1'b0;
                        state_d        = StStall;
                        cnt_d          = StallInit;
                    end
                end
                StStall: begin
                    if (cnt_q != 2'd0) begin
                        pc_write_en    = 1'b0;
                        IF_ID_write_en = 1'b0;
                        ctr_sel        = 1'b0;
                        cnt_d          = cnt_q - 2'd1;
                    end else begin
                        // Release cycle: detection stays masked so a dependent
                        // load cannot re-trigger on itself.
                        state_d = StRun;
                    end
                end
                default: begin
                    state_d = StRun;
                    cnt_d   = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StRun;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || perf_clr) begin
            stall_count_q <= 16'd0;
            flush_count_q <= 16'd0;
        end else begin
            if (!pc_write_en && (stall_count_q != 16'hFFFF)) begin
                stall_count_q <= stall_count_q + 16'd1;
            end
            if (IF_ID_flush && (flush_count_q != 16'hFFFF)) begin
                flush_count_q <= flush_count_q + 16'd1;
            end
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: two instances (STALL_CYCLES=1 and 3) share
// the same stimulus; each comparison goes through check_eq.
module tb_hazard_ctrl;

    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpReg   = 7'b0110011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpImm   = 7'b0010011;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] IF_ID_inst_opcode;
    logic [4:0] IF_ID_rs1;
    logic [4:0] IF_ID_rs2;
    logic [6:0] ID_EX_inst_opcode;
    logic [4:0] ID_EX_rd;
    logic       ID_EX_pc_sel;
    logic       perf_clr;

    logic        d1_pcw, d1_ifw, d1_flush, d1_ctr;
    logic [15:0] d1_stall, d1_flushc;
    logic        d3_pcw, d3_ifw, d3_flush, d3_ctr;
    logic [15:0] d3_stall, d3_flushc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_ADDR_WIDTH(5), .STALL_CYCLES(1)) u_dut1 (
        .clk               (clk),
        .reset             (reset),
        .IF_ID_inst_opcode (IF_ID_inst_opcode),
        .IF_ID_rs1         (IF_ID_rs1),
        .IF_ID_rs2         (IF_ID_rs2),
        .ID_EX_inst_opcode (ID_EX_inst_opcode),
        .ID_EX_rd          (ID_EX_rd),
        .ID_EX_pc_sel      (ID_EX_pc_sel),
        .perf_clr          (perf_clr),
        .pc_write_en       (d1_pcw),
        .IF_ID_write_en    (d1_ifw),
        .IF_ID_flush       (d1_flush),
        .ctr_sel           (d1_ctr),
        .stall_count       (d1_stall),
        .flush_count       (d1_flushc)
    );

    hazard_ctrl #(.REG_ADDR_WIDTH(5), .STALL_CYCLES(3)) u_dut3 (
        .clk               (clk),
        .reset             (reset),
        .IF_ID_inst_opcode (IF_ID_inst_opcode),
        .IF_ID_rs1         (IF_ID_rs1),
        .IF_ID_rs2         (IF_ID_rs2),
        .ID_EX_inst_opcode (ID_EX_inst_opcode),
        .ID_EX_rd          (ID_EX_rd),
        .ID_EX_pc_sel      (ID_EX_pc_sel),
        .perf_clr          (perf_clr),
        .pc_write_en       (d3_pcw),
        .IF_ID_write_en    (d3_ifw),
        .IF_ID_flush       (d3_flush),
        .ctr_sel           (d3_ctr),
        .stall_count       (d3_stall),
        .flush_count       (d3_flushc)
    );

    // Outputs packed as {pc_write_en, IF_ID_write_en, ctr_sel, IF_ID_flush}.
    logic [3:0] d1_out, d3_out;
    assign d1_out = {d1_pcw, d1_ifw, d1_ctr, d1_flush};
    assign d3_out = {d3_pcw, d3_ifw, d3_ctr, d3_flush};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] id_op, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [6:0] ex_op, input logic [4:0] rd, input logic pc_sel);
        IF_ID_inst_opcode = id_op;
        IF_ID_rs1         = rs1;
        IF_ID_rs2         = rs2;
        ID_EX_inst_opcode = ex_op;
        ID_EX_rd          = rd;
        ID_EX_pc_sel      = pc_sel;
    endtask

    task automatic do_reset();
        drive(7'd0, 5'd0, 5'd0, 7'd0, 5'd0, 1'b0);
        perf_clr = 1'b0;
        reset    = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        perf_clr = 1'b0;
        reset    = 1'b1;
        drive(7'd0, 5'd0, 5'd0, 7'd0, 5'd0, 1'b0);
        tick();
        tick();
        check_eq("reset_outs_d1", d1_out, 4'b0000);
        check_eq("reset_outs_d3", d3_out, 4'b0000);
        reset = 1'b0;
        #1;
        check_eq("run_outs_after_reset", d1_out, 4'b1110);
        check_eq("stall_cnt_after_reset", d1_stall, 16'd0);
        check_eq("flush_cnt_after_reset", d3_flushc, 16'd0);

        // Load-use on rs1: lw x5 in EX, consumer of x5 in ID.
        drive(OpReg, 5'd5, 5'd0, OpLoad, 5'd5, 1'b0);
        #1;
        check_eq("lu_detect_d1", d1_out, 4'b0000);
        check_eq("lu_detect_d3", d3_out, 4'b0000);
        tick();
        // Hazard held through the release cycle must not re-trigger.
        check_eq("lu_release_d1", d1_out, 4'b1110);
        check_eq("lu_stallcnt_d1", d1_stall, 16'd1);
        check_eq("lu_frozen2_d3", d3_out, 4'b0000);
        tick();
        drive(OpImm, 5'd0, 5'd0, 7'd0, 5'd0, 1'b0);
        #1;
        check_eq("lu_run_d1", d1_out, 4'b1110);
        check_eq("lu_frozen3_d3", d3_out, 4'b0000);
        check_eq("lu_stallcnt2_d3", d3_stall, 16'd2);
        tick();
        check_eq("lu_release_d3", d3_out, 4'b1110);
        check_eq("lu_stallcnt_d3", d3_stall, 16'd3);
        tick();
        check_eq("lu_run_d3", d3_out, 4'b1110);
        check_eq("lu_stallcnt_hold_d1", d1_stall, 16'd1);

        // Non-hazards: rd=0, rs2 match on an I-type, and a non-load producer.
        drive(OpReg, 5'd0, 5'd0, OpLoad, 5'd0, 1'b0);
        #1;
        check_eq("rd0_nostall", d1_out, 4'b1110);
        tick();
        drive(OpImm, 5'd3, 5'd7, OpLoad, 5'd7, 1'b0);
        #1;
        check_eq("itype_rs2_nostall", d3_out, 4'b1110);
        tick();
        drive(OpReg, 5'd7, 5'd0, OpReg, 5'd7, 1'b0);
        #1;
        check_eq("nonload_nostall", d1_out, 4'b1110);
        tick();
        check_eq("nostall_cnt_d1", d1_stall, 16'd1);
        check_eq("nostall_cnt_d3", d3_stall, 16'd3);

        // Store consuming rs2 is a real hazard.
        drive(OpStore, 5'd3, 5'd7, OpLoad, 5'd7, 1'b0);
        #1;
        check_eq("store_rs2_stall", d1_out, 4'b0000);
        tick();
        drive(OpImm, 5'd0, 5'd0, 7'd0, 5'd0, 1'b0);
        tick();
        tick();
        tick();
        check_eq("store_cnt_d1", d1_stall, 16'd2);
        check_eq("store_cnt_d3", d3_stall, 16'd6);

        // Redirect while d3 is in STALL with cnt=1.
        do_reset();
        drive(OpReg, 5'd5, 5'd0, OpLoad, 5'd5, 1'b0);
        tick();
        drive(OpImm, 5'd0, 5'd0, 7'd0, 5'd0, 1'b0);
        tick();
        drive(OpImm, 5'd0, 5'd0, 7'd0, 5'd0, 1'b1);
        #1;
        check_eq("pcsel_in_stall_outs", d3_out, 4'b1101);
        tick();
        check_eq("pcsel_flushcnt_d3", d3_flushc, 16'd1);
        check_eq("pcsel_stallcnt_d3", d3_stall, 16'd2);
        // Back in RUN: a fresh hazard freezes immediately.
        drive(OpReg, 5'd5, 5'd0, OpLoad, 5'd5, 1'b0);
        #1;
        check_eq("pcsel_then_run_d3", d3_out, 4'b0000);
        // Redirect masks detection in RUN.
        ID_EX_pc_sel = 1'b1;
        #1;
        check_eq("pcsel_masks_hazard", d3_out, 4'b1101);
        tick();
        drive(OpImm, 5'd0, 5'd0, 7'd0, 5'd0, 1'b0);
        #1;
        check_eq("pcsel_flushcnt2_d3", d3_flushc, 16'd2);
        check_eq("pcsel_recover_d3", d3_out, 4'b1110);

        // Reset while d3 is mid-stall.
        drive(OpReg, 5'd5, 5'd0, OpLoad, 5'd5, 1'b0);
        tick();
        drive(OpImm, 5'd0, 5'd0, 7'd0, 5'd0, 1'b0);
        reset = 1'b1;
        #1;
        check_eq("rst_in_stall_d3", d3_out, 4'b0000);
        check_eq("rst_in_release_d1", d1_out, 4'b0000);
        tick();
        reset = 1'b0;
        #1;
        check_eq("rst_release_outs_d3", d3_out, 4'b1110);
        check_eq("rst_release_stall_d3", d3_stall, 16'd0);
        check_eq("rst_release_flush_d3", d3_flushc, 16'd0);
        tick();
        check_eq("rst_no_resume_d3", d3_out, 4'b1110);

        // Saturation: hazard held, d3 freezes 3 of every 4 cycles.
        do_reset();
        drive(OpReg, 5'd5, 5'd0, OpLoad, 5'd5, 1'b0);
        repeat (21845 * 4) @(posedge clk);
        #1;
        check_eq("sat_reach_d3", d3_stall, 16'hFFFF);
        check_eq("sat_refreeze_d3", d3_out, 4'b0000);
        repeat (4) @(posedge clk);
        #1;
        check_eq("sat_hold_d3", d3_stall, 16'hFFFF);
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        #1;
        check_eq("clr_stall_d3", d3_stall, 16'd0);
        check_eq("clr_stall_d1", d1_stall, 16'd0);
        check_eq("clr_fsm_unaffected_d3", d3_out, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
